// File: rtl/counter_sum_accum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// counter_sum_accum : reduces NLANES 3-bit column counts per beat through a
//                     registered two-level adder tree and accumulates per frame
// Revision          : 1.0
// ============================================================================

module counter_sum_accum #(
  parameter int    NLANES   = 8,
  parameter int    ACCW     = 16,
  parameter int    BEATW    = 16,
  parameter string SATURATE = "FALSE"
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3*NLANES-1:0] in_cnt,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACCW-1:0]     out_sum,
  output logic                out_ovf,
  output logic [BEATW-1:0]    out_beats
);

  localparam int              NPAIR   = NLANES / 2;
  localparam int              TOTW    = $clog2(7 * NLANES + 1);
  localparam int              ACCW1   = ACCW + 1;
  localparam bit              SAT_EN  = (SATURATE == "TRUE");
  localparam logic [ACCW-1:0] ACC_MAX = '1;

  logic stall;
  logic accept;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  // First tree level: adjacent lanes summed before the S1 register.
  logic [3:0] pair_sum [NPAIR];

  for (genvar p = 0; p < NPAIR; p++) begin : g_pair
    assign pair_sum[p] = {1'b0, in_cnt[6*p +: 3]} + {1'b0, in_cnt[6*p+3 +: 3]};
  end

  logic [3:0] s1_sum [NPAIR];
  logic       s1_valid;
  logic       s1_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int p = 0; p < NPAIR; p++) begin
        s1_sum[p] <= '0;
      end
    end else if (!stall) begin
      s1_valid <= accept;
      s1_last  <= accept && in_last;
      if (accept) begin
        for (int p = 0; p < NPAIR; p++) begin
          s1_sum[p] <= pair_sum[p];
        end
      end
    end
  end

  logic [TOTW-1:0] tree_sum;

  always_comb begin
    tree_sum = '0;
    for (int p = 0; p < NPAIR; p++) begin
      tree_sum = tree_sum + TOTW'(s1_sum[p]);
    end
  end

  logic [TOTW-1:0] s2_total;
  logic            s2_valid;
  logic            s2_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_total <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      if (s1_valid) begin
        s2_total <= tree_sum;
      end
    end
  end

  logic [ACCW-1:0]  acc;
  logic [BEATW-1:0] beats;
  logic             ovf_sticky;
  logic [ACCW:0]    acc_next;
  logic             acc_ovf;
  logic [ACCW-1:0]  acc_upd;

  // Once a saturating frame has clamped it stays pinned until the frame ends.
  always_comb begin
    acc_next = {1'b0, acc} + ACCW1'(s2_total);
    acc_ovf  = acc_next[ACCW];
    if (SAT_EN && (acc_ovf || ovf_sticky)) begin
      acc_upd = ACC_MAX;
    end else begin
      acc_upd = acc_next[ACCW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      beats      <= '0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_ovf    <= 1'b0;
      out_beats  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (!stall && s2_valid) begin
        if (s2_last) begin
          out_valid  <= 1'b1;
          out_sum    <= acc_upd;
          out_ovf    <= ovf_sticky || acc_ovf;
          out_beats  <= beats + BEATW'(1);
          acc        <= '0;
          beats      <= '0;
          ovf_sticky <= 1'b0;
        end else begin
          acc        <= acc_upd;
          beats      <= beats + BEATW'(1);
          ovf_sticky <= ovf_sticky || acc_ovf;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_counter_sum_accum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_counter_sum_accum : directed table, stall/reset sequences and random
//                        frames against a frame-level arithmetic model
// Revision             : 1.0
// ============================================================================

module tb_counter_sum_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] in_cnt;
  logic        in_last;
  logic        out_ready;

  logic        in_ready,    out_valid,    out_ovf;
  logic [15:0] out_sum,     out_beats;
  logic        in_ready_w8, out_valid_w8, out_ovf_w8;
  logic [7:0]  out_sum_w8;
  logic [15:0] out_beats_w8;
  logic        in_ready_s8, out_valid_s8, out_ovf_s8;
  logic [7:0]  out_sum_s8;
  logic [15:0] out_beats_s8;

  counter_sum_accum dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_cnt(in_cnt), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf),
    .out_beats(out_beats)
  );

  counter_sum_accum #(.NLANES(8), .ACCW(8), .BEATW(16), .SATURATE("FALSE")) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w8),
    .in_cnt(in_cnt), .in_last(in_last), .out_valid(out_valid_w8),
    .out_ready(out_ready), .out_sum(out_sum_w8), .out_ovf(out_ovf_w8),
    .out_beats(out_beats_w8)
  );

  counter_sum_accum #(.NLANES(8), .ACCW(8), .BEATW(16), .SATURATE("TRUE")) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s8),
    .in_cnt(in_cnt), .in_last(in_last), .out_valid(out_valid_s8),
    .out_ready(out_ready), .out_sum(out_sum_s8), .out_ovf(out_ovf_s8),
    .out_beats(out_beats_s8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_xfer = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic int lane_total(input logic [23:0] c);
    int s = 0;
    for (int i = 0; i < 8; i++) s += int'(c[3*i +: 3]);
    return s;
  endfunction

  // Frame-level reference: true frame sum and beat count, reduced to each
  // instance's width/overflow policy only when the result is consumed.
  typedef struct { longint sum; int beats; } frame_t;
  frame_t exp_q[$];
  longint fsum = 0;
  int     fbeats = 0;
  bit     hold_prev = 0;
  logic [15:0] prev_sum, prev_beats;
  logic        prev_ovf;

  always @(negedge clk) begin
    if (!rst_n) begin
      fsum = 0;
      fbeats = 0;
      exp_q.delete();
      hold_prev = 0;
    end else begin
      if (out_valid && out_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          fail_now("spurious_result");
        end else begin
          frame_t e;
          e = exp_q.pop_front();
          check("sum16",    out_sum,      e.sum % 65536);
          check("ovf16",    out_ovf,      longint'(e.sum >= 65536));
          check("beats",    out_beats,    e.beats % 65536);
          check("valid_w8", out_valid_w8, 1);
          check("sum_w8",   out_sum_w8,   e.sum % 256);
          check("ovf_w8",   out_ovf_w8,   longint'(e.sum >= 256));
          check("beats_w8", out_beats_w8, e.beats % 65536);
          check("valid_s8", out_valid_s8, 1);
          check("sum_s8",   out_sum_s8,   (e.sum > 255) ? 255 : e.sum);
          check("ovf_s8",   out_ovf_s8,   longint'(e.sum >= 256));
        end
      end
      if (hold_prev) begin
        check("hold_sum",   out_sum,   prev_sum);
        check("hold_ovf",   out_ovf,   prev_ovf);
        check("hold_beats", out_beats, prev_beats);
        check("hold_valid", out_valid, 1);
      end
      hold_prev  = out_valid && !out_ready;
      prev_sum   = out_sum;
      prev_ovf   = out_ovf;
      prev_beats = out_beats;
      check("in_ready", in_ready, longint'(!(out_valid && !out_ready)));
      if (in_valid && in_ready) begin
        fsum += lane_total(in_cnt);
        fbeats++;
        if (in_last) begin
          exp_q.push_back('{sum: fsum, beats: fbeats});
          fsum = 0;
          fbeats = 0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic drive_beat(input logic [23:0] c, input bit last);
    int w = 0;
    in_valid = 1'b1;
    in_cnt   = c;
    in_last  = last;
    @(negedge clk);
    while (!in_ready) begin
      w++;
      if (w > 200) begin
        fail_now("in_ready_wait");
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) fail_now("out_valid_wait");
  endtask

  typedef struct {
    logic [23:0] cnt;
    bit          last;
    int          sum16;
    int          beats;
    bit          ovf16;
    int          sum_w8;
    bit          ovf_w8;
    int          sum_s8;
    bit          ovf_s8;
  } vec_t;

  vec_t tbl [11];
  bit   rand_done = 0;

  initial begin
    int n;
    int x0;
    longint t0;

    tbl[0]  = '{24'hFFFFFF, 1'b1, 56, 1, 1'b0, 56, 1'b0, 56, 1'b0};
    tbl[1]  = '{24'hFAC688, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[2]  = '{24'hFFFFFF, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[3]  = '{24'h000000, 1'b1, 84, 3, 1'b0, 84, 1'b0, 84, 1'b0};
    tbl[4]  = '{24'hFFFFFF, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[5]  = '{24'hFFFFFF, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[6]  = '{24'hFFFFFF, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[7]  = '{24'hFFFFFF, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[8]  = '{24'hFFFFFF, 1'b1, 280, 5, 1'b0, 24, 1'b1, 255, 1'b1};
    tbl[9]  = '{24'h249249, 1'b1, 8, 1, 1'b0, 8, 1'b0, 8, 1'b0};
    tbl[10] = '{24'h6DB6DB, 1'b1, 24, 1, 1'b0, 24, 1'b0, 24, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_cnt = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum",   out_sum,   0);
    check("rst_out_ovf",   out_ovf,   0);
    check("rst_out_beats", out_beats, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      drive_beat(tbl[i].cnt, tbl[i].last);
      if (tbl[i].last) begin
        wait_out_valid(n);
        check("tbl_latency", n, 3);
        check("tbl_sum16",   out_sum,    tbl[i].sum16);
        check("tbl_beats",   out_beats,  tbl[i].beats);
        check("tbl_ovf16",   out_ovf,    tbl[i].ovf16);
        check("tbl_sum_w8",  out_sum_w8, tbl[i].sum_w8);
        check("tbl_ovf_w8",  out_ovf_w8, tbl[i].ovf_w8);
        check("tbl_sum_s8",  out_sum_s8, tbl[i].sum_s8);
        check("tbl_ovf_s8",  out_ovf_s8, tbl[i].ovf_s8);
        @(posedge clk); #1;
      end
    end

    // Two single-beat frames held behind a stalled consumer.
    out_ready = 1'b0;
    drive_beat(24'hFFFFFF, 1'b1);
    drive_beat(24'hFAC688, 1'b1);
    wait_out_valid(n);
    for (int k = 0; k < 4; k++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_sum",      out_sum,  56);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_first_sum", out_sum, 56);
    @(negedge clk);
    check("release_second_valid", out_valid, 1);
    check("release_second_sum",   out_sum,   28);
    @(negedge clk);
    check("release_drained", out_valid, 0);
    @(posedge clk); #1;

    // One-beat frames back to back: one result per cycle, no input bubbles.
    x0 = n_xfer;
    t0 = $time;
    for (int k = 0; k < 16; k++) drive_beat(24'($urandom()), 1'b1);
    check("cont_cycles", ($time - t0) / 10, 16);
    repeat (4) @(negedge clk);
    check("cont_results", n_xfer - x0, 16);
    @(posedge clk); #1;

    // Long frame that crosses 2^16.
    for (int k = 0; k < 1200; k++) drive_beat(24'hFFFFFF, k == 1199);
    wait_out_valid(n);
    check("long_sum16", out_sum,    1664);
    check("long_ovf16", out_ovf,    1);
    check("long_beats", out_beats,  1200);
    check("long_sum_s8", out_sum_s8, 255);
    @(posedge clk); #1;

    fork
      begin
        for (int f = 0; f < 40; f++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) begin
              in_cnt  = 24'($urandom());
              in_last = 1'($urandom_range(0, 1));
              @(posedge clk); #1;
              in_last = 1'b0;
            end
            drive_beat(24'($urandom()), b == len - 1);
          end
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Reset in the middle of a frame; the partial frame must vanish.
    drive_beat(24'hFFFFFF, 1'b0);
    drive_beat(24'hFFFFFF, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    check("midrst_sum",   out_sum,   0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_beat(24'h249249, 1'b1);
    wait_out_valid(n);
    check("postrst_latency", n, 3);
    check("postrst_sum",     out_sum,   8);
    check("postrst_beats",   out_beats, 1);
    check("postrst_ovf",     out_ovf,   0);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/counter_sum_accum.md
Name: counter_sum_accum

Overview:
- Downstream consumer of an array of (1,5) column-counter cells. Each cell delivers a 3-bit count of 0..7: five weight-1 bits plus one weight-2 bit.
- The block reduces NLANES lane counts per beat through a registered two-level adder tree.
- It accumulates the beat totals over a frame delimited by in_last.
- It presents one frame total per frame on a valid/ready output.
- Target use: popcount and weight-sum reduction after the LUT6CY compressor layer.

Parameters:
- NLANES, 8, number of 3-bit lane counts per beat; even, 2..32.
- ACCW, 16, accumulator and out_sum width; must be >= clog2(7*NLANES+1).
- BEATW, 16, width of the frame beat counter.
- SATURATE, "FALSE", "TRUE" clamps the frame sum at 2^ACCW-1; "FALSE" wraps modulo 2^ACCW.

Ports:
- clk, input, 1, sole clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, block accepts a beat this cycle.
- in_cnt, input, 3*NLANES, lane i is in_cnt[3i+2:3i], unsigned 0..7.
- in_last, input, 1, this beat is the final beat of the frame.
- out_valid, output, 1, frame result valid.
- out_ready, input, 1, consumer takes the result.
- out_sum, output, ACCW, frame total.
- out_ovf, output, 1, an overflow or clamp occurred in this frame.
- out_beats, output, BEATW, number of beats accepted in this frame, wraps modulo 2^BEATW.

Behaviour:
- Reset values: in_ready=1 once rst_n deasserts. out_valid=0, out_sum=0, out_ovf=0, out_beats=0. All pipeline valid bits, the accumulator, the beat counter and the sticky overflow are 0.
- Reset mid-frame discards the partial frame and any pending result. No output is produced for it.
- stall = out_valid && !out_ready. in_ready = !stall.
- While stall is high, every pipeline register holds. The accumulator holds. Beats offered with in_valid=1 are not accepted.
- A beat is accepted at edge E when in_valid && in_ready. At E the pairwise lane sums are registered into stage S1: NLANES/2 values, each 4 bits, range 0..14, with the valid bit and last flag.
- At edge E+1, stage S2 registers the full beat total: width clog2(7*NLANES+1), max 7*NLANES, with valid and last.
- At edge E+2, the accumulate step runs. next = acc + S2.total, computed at ACCW+1 bits. The beat counter increments. Overflow (bit ACCW set) sets the sticky ovf.
- Overflow with SATURATE="TRUE": the accumulator becomes 2^ACCW-1 and stays clamped for the rest of the frame.
- Overflow with SATURATE="FALSE": the accumulator keeps the low ACCW bits.
- If S2.last is set at E+2:
  - out_sum, out_ovf and out_beats load the final values, including this beat.
  - out_valid is set.
  - The accumulator, beat counter and sticky ovf clear to 0 in the same edge.
  - Result latency: out_valid is high in the cycle after E+2 for a last beat accepted at E.
- Output handshake: the result is transferred at an edge where out_valid && out_ready.
  - out_valid drops unless a new frame result loads at that same edge.
  - If a new result loads at that edge, out_valid stays 1 and the new values replace the old.
- Output fields are stable while out_valid=1 and out_ready=0.
- Back-to-back frames need no bubble: a first beat accepted at E+1 after a last at E starts from a cleared accumulator.
- A single-beat frame (in_last on the first beat) is legal.
- in_last with in_valid=0 is ignored.
- No combinational path from in_* to out_*.
- in_ready depends only on out_valid and out_ready.

Test Plan:
- Reset, then NLANES=8, one beat of all lanes 7 with in_last=1, out_ready=1 -> out_valid is high 3 cycles after acceptance: out_sum=56, out_beats=1, out_ovf=0.
- Frame of 3 beats with lanes {0,1,2,3,4,5,6,7}, then all 7, then all 0 -> out_sum=84, out_beats=3, out_ovf=0.
- ACCW=8, SATURATE="FALSE", 5 beats of all-7 -> out_sum=24 (280 mod 256), out_ovf=1. With SATURATE="TRUE" -> out_sum=255, out_ovf=1.
- Two single-beat frames with values 56 and 28, out_ready=0 for 4 cycles:
  - in_ready falls while stalled.
  - out_sum holds at 56.
  - After out_ready=1, 28 appears with no lost or duplicated beats.
- Continuous in_valid=1 with in_last every beat and out_ready=1 -> one result per cycle, and in_ready stays 1.
- Assert rst_n=0 after 2 beats of a 4-beat frame, then send a fresh 1-beat frame of all 1s -> out_sum=8, out_beats=1, and no result for the aborted frame.
